// File: rtl/alu_operand_regfile_if.sv
// Operand/write-back/status bundle between the ALU and its register file.
// The ALU datapath is the master; the register file is the slave.
interface alu_operand_regfile_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            rd_req;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            st_we;
   logic [3:0]      st_in;
   logic [XLEN-1:0] a_out;
   logic [XLEN-1:0] b_out;
   logic            c_out;
   logic            op_valid;
   logic [3:0]      st_q;

   modport master (
      output rd_req, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, st_we, st_in,
      input  a_out, b_out, c_out, op_valid, st_q
   );

   modport slave (
      input  rd_req, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, st_we, st_in,
      output a_out, b_out, c_out, op_valid, st_q
   );
endinterface

// File: rtl/alu_operand_regfile.sv
// Architectural register file plus status-flag store feeding the ALU.
// Operands are registered one cycle after a read request; x0 is hard-wired to zero.
module alu_operand_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_operand_regfile_if.slave  rf
);

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic            valid_q;
   logic [3:0]      st_reg;

   // Read ports see a same-cycle write (write-first), but x0 always wins with zero.
   always_comb begin
      rs1_val = regs[rf.rs1_addr];
      if (rf.wr_en && (rf.wr_addr == rf.rs1_addr)) begin
         rs1_val = rf.wr_data;
      end
      if (rf.rs1_addr == '0) begin
         rs1_val = '0;
      end

      rs2_val = regs[rf.rs2_addr];
      if (rf.wr_en && (rf.wr_addr == rf.rs2_addr)) begin
         rs2_val = rf.wr_data;
      end
      if (rf.rs2_addr == '0) begin
         rs2_val = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (rf.wr_en && (rf.wr_addr != '0)) begin
         regs[rf.wr_addr] <= rf.wr_data;
      end
   end

   // Operands hold their last value when no request is made; only op_valid drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= rf.rd_req;
         if (rf.rd_req) begin
            a_q <= rs1_val;
            b_q <= rs2_val;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_reg <= '0;
      end else if (rf.st_we) begin
         st_reg <= rf.st_in;
      end
   end

   assign rf.a_out    = a_q;
   assign rf.b_out    = b_q;
   assign rf.op_valid = valid_q;
   assign rf.st_q     = st_reg;
   assign rf.c_out    = st_reg[1];

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Self-checking bench for alu_operand_regfile: a reference model predicts each read,
// expectations queue up at request time and are compared once the operands appear.
module tb_alu_operand_regfile;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   logic clk;
   logic reset;

   alu_operand_regfile_if #(.XLEN(32), .AW(5)) rf_bus ();

   alu_operand_regfile #(.XLEN(32), .NREGS(32), .AW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf_bus)
   );

   exp_t        exp_q [$];
   logic [31:0] model_regs [32];
   logic [3:0]  model_st;
   logic [31:0] last_a;
   logic [31:0] last_b;
   int          errors = 0;
   int          checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] model_value(input logic [4:0] addr, input logic we,
                                                input logic [4:0] wa, input logic [31:0] wd);
      if (addr == 5'd0) return 32'd0;
      if (we && wa == addr) return wd;
      return model_regs[addr];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_st = 4'd0;
      exp_q.delete();
   endfunction

   // One clock of stimulus; predicts the read result before the model sees this cycle's write.
   task automatic apply_stimulus(input logic rd, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic sw, input logic [3:0] si);
      exp_t e;
      @(negedge clk);
      rf_bus.rd_req   = rd;
      rf_bus.rs1_addr = s1;
      rf_bus.rs2_addr = s2;
      rf_bus.wr_en    = we;
      rf_bus.wr_addr  = wa;
      rf_bus.wr_data  = wd;
      rf_bus.st_we    = sw;
      rf_bus.st_in    = si;
      if (rd) begin
         e.a = model_value(s1, we, wa, wd);
         e.b = model_value(s2, we, wa, wd);
         exp_q.push_back(e);
      end
      @(posedge clk);
      if (we && wa != 5'd0) model_regs[wa] = wd;
      if (sw) model_st = si;
      #1;
      rf_bus.rd_req = 1'b0;
      rf_bus.wr_en  = 1'b0;
      rf_bus.st_we  = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      #1;
      checks++;
      if ({rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, rf_bus.st_q, rf_bus.c_out} !== 70'd0) begin
         errors++;
         $display("[TB] FAIL reset_initial: a=%h b=%h v=%b st=%h c=%b, required all zero",
                  rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, rf_bus.st_q, rf_bus.c_out);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i < 32; i++) apply_stimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'h100 + i, 1'b0, 4'd0);
      apply_stimulus(1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'd0, 1'b1, 4'hF);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b || rf_bus.c_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL prefill_read: a=%h b=%h c=%b, required a=%h b=%h c=1",
                  rf_bus.a_out, rf_bus.b_out, rf_bus.c_out, e.a, e.b);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, rf_bus.st_q, rf_bus.c_out} !== 70'd0) begin
         errors++;
         $display("[TB] FAIL reset_async: a=%h b=%h v=%b st=%h c=%b, required all zero",
                  rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, rf_bus.st_q, rf_bus.c_out);
      end
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus(1'b1, 5'd5, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b || rf_bus.op_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_cleared_regs: a=%h b=%h v=%b, required a=%h b=%h v=1",
                  rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, e.a, e.b);
      end
      last_a = e.a;
      last_b = e.b;
   endtask

   task automatic test_write_read();
      exp_t e;
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h0000_0001, 1'b0, 4'd0);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'hFFFF_FFFF, 1'b0, 4'd0);
      apply_stimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b || rf_bus.op_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL write_read: a=%h b=%h v=%b, required a=%h b=%h v=1",
                  rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, e.a, e.b);
      end
      last_a = e.a;
      last_b = e.b;
   endtask

   task automatic test_hold();
      apply_stimulus(1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
      checks++;
      if (rf_bus.op_valid !== 1'b0 || rf_bus.a_out !== last_a || rf_bus.b_out !== last_b) begin
         errors++;
         $display("[TB] FAIL idle_hold: a=%h b=%h v=%b, required a=%h b=%h v=0",
                  rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, last_a, last_b);
      end
   endtask

   task automatic test_bypass();
      exp_t e;
      apply_stimulus(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 4'd0);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b) begin
         errors++;
         $display("[TB] FAIL bypass_same_reg: a=%h b=%h, required a=%h b=%h",
                  rf_bus.a_out, rf_bus.b_out, e.a, e.b);
      end
      apply_stimulus(1'b1, 5'd9, 5'd2, 1'b1, 5'd2, 32'hA5A5_0F0F, 1'b0, 4'd0);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b) begin
         errors++;
         $display("[TB] FAIL bypass_port_b: a=%h b=%h, required a=%h b=%h",
                  rf_bus.a_out, rf_bus.b_out, e.a, e.b);
      end
      last_a = e.a;
      last_b = e.b;
   endtask

   task automatic test_x0();
      exp_t e;
      apply_stimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 4'd0);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b) begin
         errors++;
         $display("[TB] FAIL x0_no_bypass: a=%h b=%h, required a=%h b=%h",
                  rf_bus.a_out, rf_bus.b_out, e.a, e.b);
      end
      apply_stimulus(1'b1, 5'd0, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b) begin
         errors++;
         $display("[TB] FAIL x0_after_write: a=%h b=%h, required a=%h b=%h",
                  rf_bus.a_out, rf_bus.b_out, e.a, e.b);
      end
      last_a = e.a;
      last_b = e.b;
   endtask

   task automatic test_status();
      logic [3:0] st_seq [3];
      logic       we_seq [3];
      st_seq = '{4'b0010, 4'b0000, 4'b0000};
      we_seq = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, we_seq[i], st_seq[i]);
         checks++;
         if (rf_bus.c_out !== model_st[1] || rf_bus.st_q !== model_st) begin
            errors++;
            $display("[TB] FAIL status_step%0d: c=%b st=%h, required c=%b st=%h",
                     i, rf_bus.c_out, rf_bus.st_q, model_st[1], model_st);
         end
      end
      // Carry must not see st_in before the edge that latches it.
      @(negedge clk);
      rf_bus.st_we = 1'b1;
      rf_bus.st_in = 4'b1010;
      #1;
      checks++;
      if (rf_bus.c_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL status_no_bypass: c=%b, required c=0", rf_bus.c_out);
      end
      @(posedge clk);
      model_st = 4'b1010;
      #1;
      rf_bus.st_we = 1'b0;
      checks++;
      if (rf_bus.c_out !== 1'b1 || rf_bus.st_q !== model_st) begin
         errors++;
         $display("[TB] FAIL status_latched: c=%b st=%h, required c=1 st=%h",
                  rf_bus.c_out, rf_bus.st_q, model_st);
      end
   endtask

   task automatic test_reset_midcycle();
      exp_t e;
      apply_stimulus(1'b1, 5'd2, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b) begin
         errors++;
         $display("[TB] FAIL pre_reset_read: a=%h b=%h, required a=%h b=%h",
                  rf_bus.a_out, rf_bus.b_out, e.a, e.b);
      end
      @(negedge clk);
      rf_bus.rd_req   = 1'b1;
      rf_bus.rs1_addr = 5'd7;
      rf_bus.rs2_addr = 5'd7;
      rf_bus.wr_en    = 1'b1;
      rf_bus.wr_addr  = 5'd7;
      rf_bus.wr_data  = 32'd9;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, rf_bus.st_q, rf_bus.c_out} !== 70'd0) begin
         errors++;
         $display("[TB] FAIL midcycle_reset: a=%h b=%h v=%b st=%h c=%b, required all zero",
                  rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, rf_bus.st_q, rf_bus.c_out);
      end
      @(negedge clk);
      rf_bus.rd_req = 1'b0;
      rf_bus.wr_en  = 1'b0;
      reset = 1'b0;
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
      checks++;
      if (rf_bus.op_valid !== 1'b0 || rf_bus.a_out !== 32'd0) begin
         errors++;
         $display("[TB] FAIL post_reset_idle: a=%h v=%b, required a=0 v=0",
                  rf_bus.a_out, rf_bus.op_valid);
      end
      apply_stimulus(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
      e = exp_q.pop_front();
      checks++;
      if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b || rf_bus.op_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL r7_after_reset: a=%h b=%h v=%b, required a=%h b=%h v=1",
                  rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, e.a, e.b);
      end
   endtask

   // Fibonacci: each step writes a+b into the register that held a, then reads the pair swapped.
   task automatic test_back_to_back();
      exp_t       e;
      logic [4:0] x;
      logic [4:0] y;
      logic [4:0] t;
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'd1, 1'b0, 4'd0);
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'd1, 1'b0, 4'd0);
      apply_stimulus(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
      x = 5'd1;
      y = 5'd2;
      for (int step = 0; step <= 10; step++) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL fib_scoreboard_empty: step=%0d, required one pending read", step);
            break;
         end
         e = exp_q.pop_front();
         checks++;
         if (rf_bus.a_out !== e.a || rf_bus.b_out !== e.b || rf_bus.op_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fib_step%0d: a=%0d b=%0d v=%b, required a=%0d b=%0d v=1",
                     step, rf_bus.a_out, rf_bus.b_out, rf_bus.op_valid, e.a, e.b);
         end
         if (step < 10) begin
            apply_stimulus(1'b1, y, x, 1'b1, x, e.a + e.b, 1'b0, 4'd0);
            t = x;
            x = y;
            y = t;
         end
      end
      checks++;
      if (rf_bus.a_out !== 32'd89 || rf_bus.b_out !== 32'd144) begin
         errors++;
         $display("[TB] FAIL fib_final: a=%0d b=%0d, required a=89 b=144",
                  rf_bus.a_out, rf_bus.b_out);
      end
   endtask

   initial begin
      reset           = 1'b1;
      rf_bus.rd_req   = 1'b0;
      rf_bus.rs1_addr = 5'd0;
      rf_bus.rs2_addr = 5'd0;
      rf_bus.wr_en    = 1'b0;
      rf_bus.wr_addr  = 5'd0;
      rf_bus.wr_data  = 32'd0;
      rf_bus.st_we    = 1'b0;
      rf_bus.st_in    = 4'd0;
      model_reset();
      last_a = 32'd0;
      last_b = 32'd0;

      test_reset();
      test_write_read();
      test_hold();
      test_bypass();
      test_x0();
      test_status();
      test_reset_midcycle();
      test_back_to_back();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
